// File: rtl/spi_flash_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_master
// Description : Byte-wide SPI mode-0 master for serial flash. MSB first,
//               programmable SCK half-period, software-controlled chip select.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_master #(
  parameter int CLKDIV = 2  // clk cycles per SCK half-period, 1..255
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       wr,
  input  logic [7:0] tx_data,
  input  logic       cs_wr,
  input  logic       cs_d,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  // Terminal count of the divider for one SCK half-period.
  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

  state_t     state_q;
  logic [7:0] div_q;
  logic [2:0] bit_q;
  // Only the seven bits not yet on mosi are kept; bit 7 goes straight to mosi.
  logic [6:0] tx_sr_q;
  logic [7:0] rx_sr_q;
  logic [7:0] rx_data_q;
  logic       busy_q;
  logic       done_q;
  logic       sck_q;
  logic       mosi_q;
  logic       cs_n_q;

  logic       div_end_d;

  // End of the current half-period.
  always_comb begin
    div_end_d = (div_q == DIV_LAST);
  end

  // Transfer state machine; every output is driven straight from a register.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_q   <= S_IDLE;
      div_q     <= 8'd0;
      bit_q     <= 3'd0;
      tx_sr_q   <= 7'd0;
      rx_sr_q   <= 8'd0;
      rx_data_q <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Chip select and a new byte may be requested together; both apply.
          if (cs_wr) begin
            cs_n_q <= ~cs_d;
          end
          if (wr) begin
            tx_sr_q <= tx_data[6:0];
            mosi_q  <= tx_data[7];
            busy_q  <= 1'b1;
            div_q   <= 8'd0;
            bit_q   <= 3'd0;
            state_q <= S_LOW;
          end
        end
        S_LOW: begin
          if (div_end_d) begin
            // Rising SCK edge: the slave's bit is captured here.
            div_q   <= 8'd0;
            sck_q   <= 1'b1;
            rx_sr_q <= {rx_sr_q[6:0], miso};
            state_q <= S_HIGH;
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        S_HIGH: begin
          if (div_end_d) begin
            div_q <= 8'd0;
            sck_q <= 1'b0;
            if (bit_q == 3'd7) begin
              // Last bit: mosi keeps bit 0 until the next byte starts.
              rx_data_q <= rx_sr_q;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              bit_q   <= bit_q + 3'd1;
              mosi_q  <= tx_sr_q[6];
              tx_sr_q <= {tx_sr_q[5:0], 1'b0};
              state_q <= S_LOW;
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_master
// Description : Directed self-checking bench for spi_flash_master with a
//               mode-0 slave model and a transfer scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_master;

  localparam int CLKDIV_A = 2;
  localparam int CLKDIV_B = 1;

  logic       clk;
  logic       resetq;

  // Instance A: CLKDIV = 2
  logic       wr, cs_wr, cs_d, miso;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       busy, done, sck, mosi, cs_n;

  // Instance B: CLKDIV = 1
  logic       wr_b, cs_wr_b, cs_d_b, miso_b;
  logic [7:0] tx_data_b;
  logic [7:0] rx_data_b;
  logic       busy_b, done_b, sck_b, mosi_b, cs_n_b;

  int errors = 0;
  int checks = 0;
  int gcyc   = 0;
  int done_cnt = 0;

  // Slave model state for instance A
  logic [7:0] slave_byte;
  int         slave_idx;
  logic [7:0] mosi_cap;
  bit         cs_hi_seen;

  // Scoreboard entries: {transmitted byte, byte the slave returns}
  logic [15:0] sb_q[$];

  spi_flash_master #(.CLKDIV(CLKDIV_A)) u_dut_a (
    .clk(clk), .resetq(resetq), .wr(wr), .tx_data(tx_data),
    .cs_wr(cs_wr), .cs_d(cs_d), .rx_data(rx_data), .busy(busy),
    .done(done), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_flash_master #(.CLKDIV(CLKDIV_B)) u_dut_b (
    .clk(clk), .resetq(resetq), .wr(wr_b), .tx_data(tx_data_b),
    .cs_wr(cs_wr_b), .cs_d(cs_d_b), .rx_data(rx_data_b), .busy(busy_b),
    .done(done_b), .sck(sck_b), .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode-0 slave: present MSB before the first rising edge, advance on falling.
  assign miso = slave_byte[slave_idx[2:0]];
  always @(negedge sck) slave_idx = slave_idx - 1;

  // Bits the master puts on mosi, captured where a slave would sample them.
  always @(posedge sck) mosi_cap = {mosi_cap[6:0], mosi};

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each completed transfer against the oldest entry.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected_done: observed=done expected=no transfer pending");
      end else begin
        logic [15:0] ent;
        ent = sb_q.pop_front();
        check("sb_rx_data", {24'd0, rx_data}, {24'd0, ent[7:0]});
        check("sb_mosi_byte", {24'd0, mosi_cap}, {24'd0, ent[15:8]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    gcyc++;
  endtask

  // One byte on instance A; returns positioned in the done cycle.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] sb, input bit inject);
    int n, hi, rises, maxhi, run;
    logic prev;
    sb_q.push_back({tx, sb});
    slave_byte = sb;
    slave_idx  = 7;
    tx_data    = tx;
    wr         = 1'b1;
    tick();
    wr      = 1'b0;
    tx_data = 8'h00;
    check("busy_after_wr", {31'd0, busy}, 32'd1);
    check("mosi_msb_after_wr", {31'd0, mosi}, {31'd0, tx[7]});
    n = 1; hi = 0; rises = 0; maxhi = 0; run = 0; prev = sck;
    while (done !== 1'b1 && n < 200) begin
      if (inject && n == 5) begin
        wr = 1'b1; tx_data = 8'hFF; cs_wr = 1'b1; cs_d = 1'b0;
      end
      tick();
      n++;
      wr = 1'b0; tx_data = 8'h00; cs_wr = 1'b0; cs_d = 1'b1;
      if (sck === 1'b1) begin
        hi++;
        run++;
        if (run > maxhi) maxhi = run;
      end else begin
        run = 0;
      end
      if (sck === 1'b1 && prev !== 1'b1) rises++;
      prev = sck;
      if (cs_n !== 1'b0) cs_hi_seen = 1'b1;
    end
    check("done_latency", n, 16 * CLKDIV_A + 1);
    check("sck_pulses", rises, 8);
    check("sck_high_cycles", hi, 8 * CLKDIV_A);
    check("sck_high_run", maxhi, CLKDIV_A);
    check("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n, hi, rises, d0, d1, t_prev;
    logic prev;

    resetq = 1'b0;
    wr = 1'b1; tx_data = 8'h55; cs_wr = 1'b1; cs_d = 1'b1;
    wr_b = 1'b0; tx_data_b = 8'h00; cs_wr_b = 1'b0; cs_d_b = 1'b0; miso_b = 1'b1;
    slave_byte = 8'h00; slave_idx = 7; mosi_cap = 8'h00; cs_hi_seen = 1'b0;

    // Reset, with wr and cs_wr held high to show they are ignored.
    repeat (3) tick();
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_sck", {31'd0, sck}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_b_cs_n", {31'd0, cs_n_b}, 32'd1);
    wr = 1'b0; cs_wr = 1'b0; tx_data = 8'h00;
    resetq = 1'b1;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Select the flash, then one byte A5 against a slave returning 3C.
    cs_wr = 1'b1; cs_d = 1'b1;
    tick();
    cs_wr = 1'b0;
    check("cs_select", {31'd0, cs_n}, 32'd0);
    xfer(8'hA5, 8'h3C, 1'b0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("mosi_holds_bit0", {31'd0, mosi}, 32'd1);
    check("rx_data_stable", {24'd0, rx_data}, 32'h3C);

    // wr and cs_wr issued mid-transfer are ignored.
    d0 = done_cnt;
    xfer(8'hA5, 8'h96, 1'b1);
    repeat (40) tick();
    check("busy_ignore_done_count", done_cnt - d0, 1);
    check("busy_ignore_cs_n", {31'd0, cs_n}, 32'd0);
    check("busy_ignore_idle", {31'd0, busy}, 32'd0);

    // Three back-to-back 9F bytes, each wr issued in the previous done cycle.
    cs_hi_seen = 1'b0;
    xfer(8'h9F, 8'h11, 1'b0);
    t_prev = gcyc;
    xfer(8'h9F, 8'h22, 1'b0);
    check("b2b_spacing_1", gcyc - t_prev, 16 * CLKDIV_A + 1);
    t_prev = gcyc;
    xfer(8'h9F, 8'h33, 1'b0);
    check("b2b_spacing_2", gcyc - t_prev, 16 * CLKDIV_A + 1);
    check("b2b_cs_n_low", {31'd0, cs_hi_seen}, 32'd0);
    tick();

    // Reset in the middle of a transfer: no done, outputs back to idle.
    slave_byte = 8'h5A; slave_idx = 7;
    tx_data = 8'hC3; wr = 1'b1;
    tick();
    wr = 1'b0;
    repeat (10) tick();
    d1 = done_cnt;
    resetq = 1'b0;
    tick();
    resetq = 1'b1;
    check("abort_sck", {31'd0, sck}, 32'd0);
    check("abort_cs_n", {31'd0, cs_n}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rx_data", {24'd0, rx_data}, 32'd0);
    repeat (40) tick();
    check("abort_no_done", done_cnt - d1, 0);
    check("abort_rx_data_later", {24'd0, rx_data}, 32'd0);

    // CLKDIV=1: simultaneous cs_wr and wr, miso tied high, byte 00.
    cs_wr_b = 1'b1; cs_d_b = 1'b1; wr_b = 1'b1; tx_data_b = 8'h00;
    tick();
    cs_wr_b = 1'b0; wr_b = 1'b0;
    check("b_cs_with_wr", {31'd0, cs_n_b}, 32'd0);
    check("b_busy_with_cs", {31'd0, busy_b}, 32'd1);
    n = 1; hi = 0; rises = 0; prev = sck_b;
    while (done_b !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (sck_b === 1'b1) hi++;
      if (sck_b === 1'b1 && prev !== 1'b1) rises++;
      prev = sck_b;
    end
    check("b_done_latency", n, 16 * CLKDIV_B + 1);
    check("b_sck_pulses", rises, 8);
    check("b_sck_high_cycles", hi, 8);
    check("b_rx_data", {24'd0, rx_data_b}, 32'hFF);
    check("b_mosi_bit0", {31'd0, mosi_b}, 32'd0);

    tick();
    check("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
